multicycle_core: RTL and testbench
==================================

Name: multicycle_core

Overview:
- Parametrised multi-cycle MIPS-subset core; the next generation of our single-cycle processor.
- Each instruction runs through an FSM (FETCH, DECODE, EXEC, MEM, WB), so the ALU and register file are shared across cycles.
- Instruction and data memories are external and reached through req/ack handshakes, so the core tolerates any number of wait states.
- Adds an illegal-instruction halt and a retire strobe for benches.

Parameters:
- PC_W, 30, word-address width of pc and imem_addr; legal range 8..30.
- DMEM_AW, 5, data-memory word-address width.
- RESET_PC, 0, word address loaded into pc on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch word address; equals pc.
- imem_ack  in  1  fetch complete; imem_rdata is valid in this cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_addr  out  DMEM_AW  data word address = alu_out[DMEM_AW+1:2].
- dmem_wdata  out  32  store data (rt value).
- dmem_ack  in  1  data access complete; dmem_rdata is valid in this cycle for loads.
- dmem_rdata  in  32  load data.
- pc  out  PC_W  current program counter.
- instru  out  32  instruction register.
- state  out  3  FSM state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  high while the FSM is in HALT.

Behaviour:
- Reset (asynchronous, active-low):
  - pc=RESET_PC, instru=0, state=FETCH, all 32 registers=0.
  - imem_req, dmem_req, dmem_we, retire and halted are 0 while reset is low.
  - Reset asserted in any state, including mid-handshake, drops req immediately. No register or memory write happens in that cycle.
- Handshake:
  - req is asserted on entry to the state and held until a cycle where ack=1 is sampled. That edge completes the transfer and req deasserts on the next cycle.
  - ack may be high in the first req cycle (zero wait). ack while req=0 is ignored.
  - addr, we and wdata are stable for the whole time req is high.
- FETCH: on imem_ack, instru<=imem_rdata, pc<=pc+1 (wraps mod 2^PC_W), go to DECODE.
- DECODE: latch A=R[rs], B=R[rt]; decode the opcode.
  - j: pc<={pc[PC_W-1:26], target} (target[PC_W-1:0] when PC_W<=26); retire; go to FETCH.
  - Word 0x00000000 (nop): retire; go to FETCH.
  - Illegal opcode or funct: go to HALT; no retire.
  - All others: go to EXEC.
- EXEC: compute alu_out.
  - R-type: addu 0x21, subu 0x23, and 0x24, or 0x25, slt 0x2A (signed compare).
  - I-type: addiu 0x09 (sign-extended imm), ori 0x0D (zero-extended), lui 0x0F ({imm,16'b0}).
  - lw 0x23 / sw 0x2B address = A+sext(imm).
  - beq 0x04: if A==B, pc<=pc+sext(imm) truncated to PC_W (pc already holds PC+1; wraps). Retire and go to FETCH.
  - lw/sw go to MEM; others go to WB.
  - Overflow is ignored; all arithmetic is mod 2^32.
- MEM: dmem_req=1, with dmem_we=1 for sw.
  - sw: on ack, retire and go to FETCH.
  - lw: on ack, latch MDR<=dmem_rdata and go to WB.
- WB: write R[dst] with alu_out or MDR; dst=rd for R-type, rt otherwise. Writes to register 0 are discarded. Retire; go to FETCH.
- HALT: sticky until reset; no requests issued; pc and instru hold.
- Cycle counts at zero-wait memory: j/nop 2, beq 3, ALU ops 4, sw 4, lw 5. Each wait cycle adds one.
- Register reads in DECODE see writes retired by any earlier instruction; there is no hazard logic because instructions never overlap.

Test Plan:
- Reset low mid-FETCH with imem_req=1, then release, RESET_PC=4 -> imem_req=0 and pc=4 while reset is low; first fetch is at address 4 with state=0.
- Zero-wait program: addiu $1,$0,5; addiu $2,$0,-3; addu $3,$1,$2; slt $4,$2,$1 -> R3=2, R4=1; retire pulses at cycles 4, 8, 12, 16 after reset release.
- sw $3,8($0) then lw $5,8($0) with 2 wait cycles on dmem_ack -> dmem_addr=2, dmem_wdata=2, dmem_we=1 on the store and 0 on the load; R5=2; lw takes 7 cycles.
- beq $0,$0,-1 at pc=10 -> pc returns to 10 (tight loop). beq $1,$0,+3 with R1≠0 -> pc=pc+1.
- j 0x3FFFFFF with PC_W=8 -> pc=0xFF. Instruction with opcode 0x3F -> halted=1, state=7, no further imem_req, and no retire for that instruction.
- addiu $0,$0,7 then addu $6,$0,$0 -> R6=0 (register 0 stays zero).

Source files
------------

// File: rtl/multicycle_core.sv
// Multi-cycle MIPS-subset core: one FSM walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// sharing a single ALU and register file, with req/ack handshakes to external memories.
module multicycle_core #(
    parameter int PC_W     = 30,
    parameter int DMEM_AW  = 5,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic               dmem_ack,
    input  logic [31:0]        dmem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic [31:0]        instru,
    output logic [2:0]         state,
    output logic               retire,
    output logic               halted
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] F_ADDU   = 6'h21;
    localparam logic [5:0] F_SUBU   = 6'h23;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_SLT    = 6'h2A;

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     ir_q;
    logic            retire_q;
    logic [31:0]     rf [32];
    logic [31:0]     a_q, b_q, alu_q, mdr_q;

    logic [5:0]         opcode, funct;
    logic [4:0]         rs, rt, rd, dst;
    logic [15:0]        imm;
    logic [31:0]        imm_sext, imm_zext, alu_res, wb_data;
    logic signed [31:0] a_s, b_s;
    logic               legal;
    logic [PC_W-1:0]    jump_pc;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm      = ir_q[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'd0, imm};
    assign a_s      = a_q;
    assign b_s      = b_q;
    assign dst      = (opcode == OP_R) ? rd : rt;
    assign wb_data  = (opcode == OP_LW) ? mdr_q : alu_q;

    // Jump keeps the pc bits above the 26-bit target field when pc is wide enough to have any.
    generate
        if (PC_W > 26) begin : g_jump_wide
            assign jump_pc = {pc_q[PC_W-1:26], ir_q[25:0]};
        end else begin : g_jump_narrow
            assign jump_pc = ir_q[PC_W-1:0];
        end
    endgenerate

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R:    legal = funct inside {F_ADDU, F_SUBU, F_AND, F_OR, F_SLT};
            OP_J, OP_BEQ, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = 32'd0;
        if (opcode == OP_R) begin
            case (funct)
                F_ADDU:  alu_res = a_q + b_q;
                F_SUBU:  alu_res = a_q - b_q;
                F_AND:   alu_res = a_q & b_q;
                F_OR:    alu_res = a_q | b_q;
                F_SLT:   alu_res = {31'd0, (a_s < b_s)};
                default: alu_res = 32'd0;
            endcase
        end else begin
            case (opcode)
                OP_ADDIU, OP_LW, OP_SW: alu_res = a_q + imm_sext;
                OP_ORI:  alu_res = a_q | imm_zext;
                OP_LUI:  alu_res = {imm, 16'd0};
                default: alu_res = 32'd0;
            endcase
        end
    end

    // Control state, pc, instruction register and register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            pc_q     <= PC_W'(RESET_PC);
            ir_q     <= 32'd0;
            retire_q <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir_q    <= imem_rdata;
                        pc_q    <= pc_q + PC_W'(1);
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (ir_q == 32'd0) begin
                        retire_q <= 1'b1;
                        state_q  <= S_FETCH;
                    end else if (!legal) begin
                        state_q <= S_HALT;
                    end else if (opcode == OP_J) begin
                        pc_q     <= jump_pc;
                        retire_q <= 1'b1;
                        state_q  <= S_FETCH;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (opcode == OP_BEQ) begin
                        if (a_q == b_q) pc_q <= pc_q + imm_sext[PC_W-1:0];
                        retire_q <= 1'b1;
                        state_q  <= S_FETCH;
                    end else if (opcode == OP_LW || opcode == OP_SW) begin
                        state_q <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (opcode == OP_SW) begin
                            retire_q <= 1'b1;
                            state_q  <= S_FETCH;
                        end else begin
                            state_q <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (dst != 5'd0) rf[dst] <= wb_data;
                    retire_q <= 1'b1;
                    state_q  <= S_FETCH;
                end
                default: state_q <= S_HALT;
            endcase
        end
    end

    // Datapath latches carry no reset; each is only consumed after the state that loads it.
    always_ff @(posedge clk) begin
        if (state_q == S_DECODE) begin
            a_q <= rf[rs];
            b_q <= rf[rt];
        end
        if (state_q == S_EXEC) alu_q <= alu_res;
        if (state_q == S_MEM && dmem_ack) mdr_q <= dmem_rdata;
    end

    assign imem_req   = reset && (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = dmem_req && (opcode == OP_SW);
    assign dmem_addr  = alu_q[DMEM_AW+1:2];
    assign dmem_wdata = b_q;
    assign pc         = pc_q;
    assign instru     = ir_q;
    assign state      = state_q;
    assign retire     = retire_q;
    assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: small programs in a bench-side memory with
// programmable wait states; results are observed through stores and core outputs.
module tb_multicycle_core;
    localparam int PC_W = 8;
    localparam int DMEM_AW = 5;
    localparam int RESET_PC = 4;
    localparam logic [31:0] ILLEGAL = 32'hFC000000;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               imem_req, imem_ack;
    logic [PC_W-1:0]    imem_addr;
    logic [31:0]        imem_rdata;
    logic               dmem_req, dmem_we, dmem_ack;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [31:0]        dmem_wdata, dmem_rdata;
    logic [PC_W-1:0]    pc;
    logic [31:0]        instru;
    logic [2:0]         state;
    logic               retire, halted;

    logic [31:0]        imem [256];
    logic [31:0]        dmem [32];
    int                 imem_wait = 0;
    int                 dmem_wait = 0;
    logic [DMEM_AW-1:0] st_addr;
    logic [31:0]        st_wdata;
    logic               st_we;

    int tests_run = 0;
    int tests_failed = 0;

    multicycle_core #(.PC_W(PC_W), .DMEM_AW(DMEM_AW), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc(pc), .instru(instru), .state(state), .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    // Instruction memory responder: ack after imem_wait cycles of held request.
    initial begin
        int cnt;
        cnt = 0;
        imem_ack = 1'b0;
        imem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            if (imem_req) begin
                if (cnt >= imem_wait) begin
                    imem_ack = 1'b1;
                    imem_rdata = imem[imem_addr];
                    cnt = 0;
                end else begin
                    imem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    // Data memory responder: records the request seen on the completing cycle.
    initial begin
        int cnt;
        cnt = 0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            if (dmem_req) begin
                if (cnt >= dmem_wait) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = dmem[dmem_addr];
                    st_addr = dmem_addr;
                    st_wdata = dmem_wdata;
                    st_we = dmem_we;
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    cnt = 0;
                end else begin
                    dmem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                dmem_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required to have finished");
        $fatal(1);
    end

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_type(input logic [25:0] target);
        return {6'h02, target};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = ILLEGAL;
        for (int i = 0; i < 32; i++) dmem[i] = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Returns the number of rising edges until retire is seen, or -1 on timeout.
    task automatic wait_retire(output int cyc);
        cyc = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (retire) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int cyc;
        clear_mem();
        imem_wait = 3;
        dmem_wait = 0;
        imem[4] = j_type(26'd20);
        do_reset();
        wait_retire(cyc);
        tests_run++;
        if (cyc !== 5) begin tests_failed++; $display("FAIL reset_j_wait3_cycles: got %0d expected 5", cyc); end
        tests_run++;
        if (pc !== 8'd20) begin tests_failed++; $display("FAIL reset_j_pc: got %0d expected 20", pc); end
        repeat (2) @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 8'd20) begin
            tests_failed++;
            $display("FAIL reset_pre_req: got req=%b addr=%0d expected req=1 addr=20", imem_req, imem_addr);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req_drop: got %b expected 0", imem_req); end
        tests_run++;
        if (pc !== 8'd4 || state !== 3'd0 || instru !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got pc=%0d state=%0d ir=%h expected pc=4 state=0 ir=0", pc, state, instru);
        end
        @(negedge clk);
        tests_run++;
        if (retire !== 1'b0 || halted !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got retire=%b halted=%b dreq=%b we=%b ireq=%b expected all 0",
                     retire, halted, dmem_req, dmem_we, imem_req);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 8'd4 || state !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_first_fetch: got req=%b addr=%0d state=%0d expected req=1 addr=4 state=0",
                     imem_req, imem_addr, state);
        end
    endtask

    task automatic test_alu_zero_wait();
        int cyc;
        int total;
        clear_mem();
        imem_wait = 0;
        dmem_wait = 0;
        imem[4] = i_type(6'h09, 5'd0, 5'd1, 16'd5);
        imem[5] = i_type(6'h09, 5'd0, 5'd2, 16'hFFFD);
        imem[6] = r_type(5'd1, 5'd2, 5'd3, 6'h21);
        imem[7] = r_type(5'd2, 5'd1, 5'd4, 6'h2A);
        imem[8] = i_type(6'h2B, 5'd0, 5'd3, 16'd0);
        imem[9] = i_type(6'h2B, 5'd0, 5'd4, 16'd4);
        do_reset();
        total = 0;
        for (int k = 1; k <= 4; k++) begin
            wait_retire(cyc);
            total += cyc;
            tests_run++;
            if (total !== 4 * k) begin
                tests_failed++;
                $display("FAIL alu_retire_%0d: got cycle %0d expected cycle %0d", k, total, 4 * k);
            end
        end
        wait_retire(cyc);
        tests_run++;
        if (cyc !== 4) begin tests_failed++; $display("FAIL sw_zero_wait_cycles: got %0d expected 4", cyc); end
        wait_retire(cyc);
        tests_run++;
        if (dmem[0] !== 32'd2) begin tests_failed++; $display("FAIL addu_r3: got %h expected 00000002", dmem[0]); end
        tests_run++;
        if (dmem[1] !== 32'd1) begin tests_failed++; $display("FAIL slt_signed_r4: got %h expected 00000001", dmem[1]); end
    endtask

    task automatic test_alu_ops();
        int cyc;
        int timeouts;
        clear_mem();
        imem_wait = 0;
        dmem_wait = 0;
        imem[4]  = i_type(6'h09, 5'd0, 5'd1, 16'hFFFF);
        imem[5]  = i_type(6'h0F, 5'd0, 5'd2, 16'h1234);
        imem[6]  = i_type(6'h0D, 5'd2, 5'd2, 16'hF0F0);
        imem[7]  = i_type(6'h09, 5'd0, 5'd5, 16'h00FF);
        imem[8]  = r_type(5'd2, 5'd1, 5'd3, 6'h23);
        imem[9]  = r_type(5'd2, 5'd5, 5'd4, 6'h25);
        imem[10] = r_type(5'd2, 5'd5, 5'd6, 6'h24);
        imem[11] = i_type(6'h0D, 5'd0, 5'd7, 16'h8000);
        imem[12] = r_type(5'd1, 5'd0, 5'd8, 6'h2A);
        imem[13] = i_type(6'h2B, 5'd0, 5'd3, 16'd0);
        imem[14] = i_type(6'h2B, 5'd0, 5'd4, 16'd4);
        imem[15] = i_type(6'h2B, 5'd0, 5'd6, 16'd8);
        imem[16] = i_type(6'h2B, 5'd0, 5'd7, 16'd12);
        imem[17] = i_type(6'h2B, 5'd0, 5'd8, 16'd16);
        do_reset();
        timeouts = 0;
        for (int k = 0; k < 14; k++) begin
            wait_retire(cyc);
            if (cyc !== 4) timeouts++;
        end
        tests_run++;
        if (timeouts !== 0) begin tests_failed++; $display("FAIL aluops_cycles: got %0d off-count instrs expected 0", timeouts); end
        tests_run++;
        if (dmem[0] !== 32'h1234F0F1) begin tests_failed++; $display("FAIL subu: got %h expected 1234f0f1", dmem[0]); end
        tests_run++;
        if (dmem[1] !== 32'h1234F0FF) begin tests_failed++; $display("FAIL or: got %h expected 1234f0ff", dmem[1]); end
        tests_run++;
        if (dmem[2] !== 32'h000000F0) begin tests_failed++; $display("FAIL and: got %h expected 000000f0", dmem[2]); end
        tests_run++;
        if (dmem[3] !== 32'h00008000) begin tests_failed++; $display("FAIL ori_zext: got %h expected 00008000", dmem[3]); end
        tests_run++;
        if (dmem[4] !== 32'd1) begin tests_failed++; $display("FAIL slt_neg: got %h expected 00000001", dmem[4]); end
    endtask

    task automatic test_mem_wait();
        int cyc;
        clear_mem();
        imem_wait = 0;
        dmem_wait = 2;
        dmem[3] = 32'h55;
        imem[4] = i_type(6'h09, 5'd0, 5'd3, 16'd2);
        imem[5] = i_type(6'h2B, 5'd0, 5'd3, 16'd8);
        imem[6] = i_type(6'h23, 5'd0, 5'd5, 16'd8);
        imem[7] = i_type(6'h2B, 5'd0, 5'd5, 16'd12);
        do_reset();
        wait_retire(cyc);
        wait_retire(cyc);
        tests_run++;
        if (cyc !== 6) begin tests_failed++; $display("FAIL sw_wait2_cycles: got %0d expected 6", cyc); end
        tests_run++;
        if (st_addr !== 5'd2 || st_wdata !== 32'd2 || st_we !== 1'b1) begin
            tests_failed++;
            $display("FAIL sw_bus: got addr=%0d wdata=%h we=%b expected addr=2 wdata=2 we=1", st_addr, st_wdata, st_we);
        end
        wait_retire(cyc);
        tests_run++;
        if (cyc !== 7) begin tests_failed++; $display("FAIL lw_wait2_cycles: got %0d expected 7", cyc); end
        tests_run++;
        if (st_addr !== 5'd2 || st_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL lw_bus: got addr=%0d we=%b expected addr=2 we=0", st_addr, st_we);
        end
        wait_retire(cyc);
        tests_run++;
        if (dmem[3] !== 32'd2) begin tests_failed++; $display("FAIL lw_r5: got %h expected 00000002", dmem[3]); end
    endtask

    task automatic test_branch();
        int cyc;
        clear_mem();
        imem_wait = 0;
        dmem_wait = 0;
        imem[4]  = j_type(26'd10);
        imem[10] = i_type(6'h04, 5'd0, 5'd0, 16'hFFFF);
        do_reset();
        wait_retire(cyc);
        tests_run++;
        if (cyc !== 2 || pc !== 8'd10) begin
            tests_failed++;
            $display("FAIL j_to_10: got cycles=%0d pc=%0d expected cycles=2 pc=10", cyc, pc);
        end
        for (int k = 0; k < 2; k++) begin
            wait_retire(cyc);
            tests_run++;
            if (cyc !== 3 || pc !== 8'd10) begin
                tests_failed++;
                $display("FAIL beq_loop_%0d: got cycles=%0d pc=%0d expected cycles=3 pc=10", k, cyc, pc);
            end
        end
        clear_mem();
        imem[4] = i_type(6'h09, 5'd0, 5'd1, 16'd1);
        imem[5] = i_type(6'h04, 5'd1, 5'd0, 16'd3);
        imem[6] = i_type(6'h04, 5'd0, 5'd0, 16'd3);
        do_reset();
        wait_retire(cyc);
        wait_retire(cyc);
        tests_run++;
        if (cyc !== 3 || pc !== 8'd6) begin
            tests_failed++;
            $display("FAIL beq_not_taken: got cycles=%0d pc=%0d expected cycles=3 pc=6", cyc, pc);
        end
        wait_retire(cyc);
        tests_run++;
        if (pc !== 8'd10) begin tests_failed++; $display("FAIL beq_fwd_taken: got pc=%0d expected 10", pc); end
    endtask

    task automatic test_jump_halt();
        int cyc;
        int retires;
        int reqs;
        clear_mem();
        imem_wait = 0;
        dmem_wait = 0;
        imem[4] = j_type(26'h3FFFFFF);
        do_reset();
        wait_retire(cyc);
        tests_run++;
        if (cyc !== 2 || pc !== 8'hFF) begin
            tests_failed++;
            $display("FAIL j_max_target: got cycles=%0d pc=%h expected cycles=2 pc=ff", cyc, pc);
        end
        retires = 0;
        reqs = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (retire) retires++;
            if (halted && imem_req) reqs++;
        end
        tests_run++;
        if (halted !== 1'b1 || state !== 3'd7) begin
            tests_failed++;
            $display("FAIL halt_state: got halted=%b state=%0d expected halted=1 state=7", halted, state);
        end
        tests_run++;
        if (retires !== 0 || reqs !== 0) begin
            tests_failed++;
            $display("FAIL halt_quiet: got retires=%0d reqs=%0d expected 0 and 0", retires, reqs);
        end
        tests_run++;
        if (pc !== 8'h00 || instru !== ILLEGAL) begin
            tests_failed++;
            $display("FAIL halt_hold: got pc=%h ir=%h expected pc=00 ir=fc000000", pc, instru);
        end
        clear_mem();
        imem[4] = r_type(5'd0, 5'd0, 5'd0, 6'h20);
        do_reset();
        repeat (6) @(negedge clk);
        tests_run++;
        if (halted !== 1'b1 || state !== 3'd7 || pc !== 8'd5) begin
            tests_failed++;
            $display("FAIL halt_bad_funct: got halted=%b state=%0d pc=%0d expected halted=1 state=7 pc=5",
                     halted, state, pc);
        end
    endtask

    task automatic test_zero_reg();
        int cyc;
        clear_mem();
        imem_wait = 0;
        dmem_wait = 0;
        dmem[0] = 32'hDEAD;
        imem[4] = 32'd0;
        imem[5] = i_type(6'h09, 5'd0, 5'd0, 16'd7);
        imem[6] = r_type(5'd0, 5'd0, 5'd6, 6'h21);
        imem[7] = i_type(6'h2B, 5'd0, 5'd6, 16'd0);
        do_reset();
        wait_retire(cyc);
        tests_run++;
        if (cyc !== 2) begin tests_failed++; $display("FAIL nop_cycles: got %0d expected 2", cyc); end
        for (int k = 0; k < 3; k++) wait_retire(cyc);
        tests_run++;
        if (dmem[0] !== 32'd0) begin tests_failed++; $display("FAIL r0_stays_zero: got %h expected 00000000", dmem[0]); end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_alu_zero_wait();
        test_alu_ops();
        test_mem_wait();
        test_branch();
        test_jump_halt();
        test_zero_reg();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
